print_string_engine: RTL and testbench

PRINT_STRING_ENGINE -- requirements
Module: print_string_engine

---
 rtl/print_string_engine_pkg.sv | 21 ++
 rtl/print_string_engine.sv | 119 +++++++++++
 tb/tb_print_string_engine.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/print_string_engine_pkg.sv
// Shared processor constants: global memory window and print-engine state encoding.
package print_string_engine_pkg;

    localparam logic [31:0] PSE_GLOBAL_LO = 32'h0080_0000;
    localparam logic [31:0] PSE_GLOBAL_HI = 32'h00A0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_FINISH
    } pse_state_e;

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/print_string_engine.sv
// Byte-at-a-time string printer: fetches NUL-terminated bytes from global memory
// and hands them to a console sink with a valid/ready handshake.
module print_string_engine
    import print_string_engine_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 1024,
    parameter logic [31:0] GLOBAL_LO = PSE_GLOBAL_LO,
    parameter logic [31:0] GLOBAL_HI = PSE_GLOBAL_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        printStr,
    input  logic [31:0] strAddr,
    output logic        memRe,
    output logic [31:0] memAddr,
    input  logic [7:0]  memByte,
    input  logic        memValid,
    output logic [7:0]  charOut,
    output logic        charValid,
    input  logic        charReady,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] charCount
);

    pse_state_e  state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;
    logic [31:0] count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            byte_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            byte_q  <= byte_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Compare in 32 bits so MAX_LEN values beyond the 16-bit counter still behave.
    assign count_next = 32'(count_q) + 32'd1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        byte_d    = byte_q;
        count_d   = count_q;
        err_d     = err_q;
        memRe     = 1'b0;
        charValid = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (printStr) begin
                    ptr_d   = strAddr;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (addr_in_range(ptr_q, GLOBAL_LO, GLOBAL_HI)) begin
                    memRe   = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_WAIT: begin
                if (memValid) begin
                    if (memByte == 8'h00) begin
                        err_d   = 1'b0;
                        state_d = ST_FINISH;
                    end else begin
                        byte_d  = memByte;
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                charValid = 1'b1;
                if (charReady) begin
                    ptr_d   = ptr_q + 32'd1;
                    count_d = count_q + 16'd1;
                    if (count_next == 32'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                error   = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign memAddr   = ptr_q;
    assign charOut   = byte_q;
    assign charCount = count_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_EMIT);

endmodule

// File: tb/tb_print_string_engine.sv
// Scoreboard bench for print_string_engine: stimulus pushes expected chars/completions,
// a negedge monitor pops and compares them.
module tb_print_string_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        printStr;
    logic [31:0] strAddr;
    logic        memRe;
    logic [31:0] memAddr;
    logic [7:0]  memByte;
    logic        memValid;
    logic [7:0]  charOut;
    logic        charValid;
    logic        charReady;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] charCount;

    always #5 clk = ~clk;

    print_string_engine #(
        .MAX_LEN   (4),
        .GLOBAL_LO (32'h0080_0000),
        .GLOBAL_HI (32'h00A0_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .printStr  (printStr),
        .strAddr   (strAddr),
        .memRe     (memRe),
        .memAddr   (memAddr),
        .memByte   (memByte),
        .memValid  (memValid),
        .charOut   (charOut),
        .charValid (charValid),
        .charReady (charReady),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .charCount (charCount)
    );

    typedef struct {
        int err;
        int count;
        int busy_cycles;
        int memre;
    } done_exp_t;

    logic [7:0] exp_chars[$];
    done_exp_t  exp_done[$];
    logic [7:0] mem [logic [31:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: captures memRe at negedge, returns the byte after mem_lat edges.
    int          mem_lat = 1;
    int          lat_cnt = 0;
    bit          req_pend = 1'b0;
    logic [31:0] req_addr = '0;

    always @(negedge clk) begin
        if (memRe) begin
            req_pend = 1'b1;
            req_addr = memAddr;
            lat_cnt  = mem_lat;
        end
    end

    always @(posedge clk) begin
        #1;
        memValid = 1'b0;
        if (req_pend) begin
            lat_cnt--;
            if (lat_cnt <= 0) begin
                memValid = 1'b1;
                memByte  = mem.exists(req_addr) ? mem[req_addr] : 8'h00;
                req_pend = 1'b0;
            end
        end
    end

    // Monitor
    int         busy_cyc  = 0;
    int         memre_cnt = 0;
    bit         held_valid = 1'b0;
    logic [7:0] held_char  = '0;

    always @(negedge clk) begin
        if (reset) begin
            busy_cyc   = 0;
            memre_cnt  = 0;
            held_valid = 1'b0;
        end else begin
            if (busy)  busy_cyc++;
            if (memRe) memre_cnt++;
            if (memRe || charValid) check("re_valid_exclusive", 32'(memRe & charValid), 32'd0);
            if (held_valid) begin
                check("stall_valid_held", 32'(charValid), 32'd1);
                check("stall_char_stable", 32'(charOut), 32'(held_char));
            end
            held_valid = charValid && !charReady;
            held_char  = charOut;
            if (charValid && charReady) begin
                if (exp_chars.size() == 0) begin
                    check("unexpected_char", 32'(charOut), 32'hFFFF_FFFF);
                end else begin
                    check("char", 32'(charOut), 32'(exp_chars.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'(charCount), 32'hFFFF_FFFF);
                end else begin
                    done_exp_t d;
                    d = exp_done.pop_front();
                    check("done_error", 32'(error), 32'(d.err));
                    check("done_charCount", 32'(charCount), 32'(d.count));
                    check("done_busy_cycles", 32'(busy_cyc), 32'(d.busy_cycles));
                    check("done_memre_count", 32'(memre_cnt), 32'(d.memre));
                end
                busy_cyc  = 0;
                memre_cnt = 0;
            end
        end
    end

    task automatic start(input logic [31:0] addr);
        printStr = 1'b1;
        strAddr  = addr;
        @(posedge clk);
        #1;
        printStr = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  start_cnt;
        bit  got;
        start_cnt = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != start_cnt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({name, "_done_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_done(input int err, input int count, input int bcyc, input int mre);
        done_exp_t d;
        d.err = err; d.count = count; d.busy_cycles = bcyc; d.memre = mre;
        exp_done.push_back(d);
    endtask

    initial begin
        logic [7:0] ten[10];
        reset     = 1'b1;
        printStr  = 1'b0;
        strAddr   = '0;
        charReady = 1'b1;
        memValid  = 1'b0;
        memByte   = '0;

        mem[32'h0080_0000] = 8'h68;
        mem[32'h0080_0001] = 8'h69;
        mem[32'h0080_0002] = 8'h00;
        mem[32'h0080_0010] = 8'h00;
        ten = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A};
        for (int unsigned i = 0; i < 10; i++) mem[32'h0080_0020 + i] = ten[i];
        mem[32'h0080_002A] = 8'h00;
        mem[32'h00A0_0000] = 8'h5A;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_memRe", 32'(memRe), 32'd0);
        check("rst_charValid", 32'(charValid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        check("rst_charOut", 32'(charOut), 32'd0);
        check("rst_charCount", 32'(charCount), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // "hi" with a printStr pulse mid-string that must be ignored
        exp_chars.push_back(8'h68);
        exp_chars.push_back(8'h69);
        push_done(0, 2, 8, 3);
        start(32'h0080_0000);
        repeat (3) @(posedge clk);
        #1;
        printStr = 1'b1;
        strAddr  = 32'h1d11_0000;
        @(posedge clk);
        #1;
        printStr = 1'b0;
        wait_done("hi");

        // Sink stalls 5 cycles on the first char
        charReady = 1'b0;
        exp_chars.push_back(8'h68);
        exp_chars.push_back(8'h69);
        push_done(0, 2, 13, 3);
        start(32'h0080_0000);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (charValid) break;
        end
        check("stall_first_char", 32'(charOut), 32'h68);
        repeat (5) @(posedge clk);
        #1;
        charReady = 1'b1;
        wait_done("stall");

        // Empty string
        push_done(0, 0, 2, 1);
        start(32'h0080_0010);
        wait_done("empty");

        // MAX_LEN=4 overflow on a 10-char string
        for (int unsigned i = 0; i < 4; i++) exp_chars.push_back(ten[i]);
        push_done(1, 4, 12, 4);
        start(32'h0080_0020);
        wait_done("maxlen");
        check("count_held_after_done", 32'(charCount), 32'd4);

        // Out-of-range start address
        push_done(1, 0, 1, 0);
        start(32'h1d11_0000);
        wait_done("bad_addr");

        // Last legal byte, then pointer steps past GLOBAL_HI
        exp_chars.push_back(8'h5A);
        push_done(1, 1, 4, 1);
        start(32'h00A0_0000);
        wait_done("global_hi");

        // Just below GLOBAL_LO
        push_done(1, 0, 1, 0);
        start(32'h007F_FFFF);
        wait_done("below_lo");

        // Reset during WAIT; late memValid must be ignored
        mem_lat = 2;
        start(32'h0080_0000);
        @(negedge clk);
        check("abort_memRe_issued", 32'(memRe), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_late_memValid", 32'(memValid), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_charValid", 32'(charValid), 32'd0);
        check("abort_memRe", 32'(memRe), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        check("abort_memAddr", memAddr, 32'd0);
        check("abort_charOut", 32'(charOut), 32'd0);
        check("abort_charCount", 32'(charCount), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_still_idle", 32'(busy), 32'd0);

        // Recovery after abort
        mem_lat = 1;
        exp_chars.push_back(8'h68);
        exp_chars.push_back(8'h69);
        push_done(0, 2, 8, 3);
        start(32'h0080_0000);
        wait_done("recover");

        repeat (5) @(posedge clk);
        check("leftover_chars", 32'(exp_chars.size()), 32'd0);
        check("leftover_dones", 32'(exp_done.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
